rr_arb_4_1: RTL and testbench

- Four-requester round-robin arbiter with a valid/ready handshake on every input and on the output.
- Selects one requester per cycle and registers its 4-bit word into a single-entry output stage.
- Also registers the winning 2-bit source index. out_sel drives the select input of the 4:1 select stage downstream.
- Sits directly upstream of that stage and replaces a free-running select.

---
 rtl/rr_arb_4_1.sv | 49 ++++
 tb/tb_rr_arb_4_1.sv | 94 +++++++++
 2 files changed

// File: rtl/rr_arb_4_1.sv
// rr_arb_4_1: 4-way round-robin valid/ready arbiter feeding a registered word+source-index output stage
module rr_arb_4_1 #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_sel
);
  logic [1:0] ptr_q, ptr_d, sel_q, sel_d, g;
  logic [W-1:0] data_q, data_d;
  logic valid_q, valid_d, hit, can_load, xfer;
  always_comb begin
    g = ptr_q;
    hit = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (in_valid[ptr_q + 2'(k)]) begin
        g = ptr_q + 2'(k);
        hit = 1'b1;
      end
    can_load = !valid_q || out_ready;
    in_ready = (hit && can_load && !rst) ? 4'b1 << g : 4'b0;
    xfer = |(in_valid & in_ready);
    valid_d = xfer || (valid_q && !out_ready);
    data_d = xfer ? in_data[W*g +: W] : data_q;
    sel_d = xfer ? g : sel_q;
    ptr_d = xfer ? g + 2'd1 : ptr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q <= '0;
      sel_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_sel = sel_q;
endmodule

// File: tb/tb_rr_arb_4_1.sv
// tb_rr_arb_4_1: directed and random checks of rr_arb_4_1 against a behavioural round-robin model
module tb_rr_arb_4_1;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0, out_valid;
  logic [3:0] in_valid = '0, in_ready, out_data;
  logic [15:0] in_data = '0;
  logic [1:0] out_sel;
  int n_chk = 0, n_err = 0;
  int m_ptr = 0, m_sel = 0, m_data = 0;
  bit m_valid = 0;
  rr_arb_4_1 #(.W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ptr = 0; m_sel = 0; m_data = 0; m_valid = 0;
  endtask
  task automatic cycle(input logic [3:0] v, input logic [15:0] d, input logic r);
    int win;
    logic [3:0] er;
    in_valid = v; in_data = d; out_ready = r;
    win = -1;
    for (int i = 0; i < 4; i++)
      if (win < 0 && v[(m_ptr + i) % 4]) win = (m_ptr + i) % 4;
    er = (win >= 0 && (!m_valid || r)) ? 4'(1 << win) : 4'b0;
    #1;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    #1;
    if (er != 0) begin
      m_valid = 1; m_sel = win; m_data = int'(d[win*4 +: 4]); m_ptr = (win + 1) % 4;
    end else if (r) m_valid = 0;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_sel", out_sel, m_sel);
  endtask
  initial begin
    in_valid = 4'b1111; out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 16'hDCBA, 1'b1);
      chk("rot_sel", out_sel, k % 4);
      chk("rot_data", out_data, 4'hA + k % 4);
    end
    cycle(4'b1111, 16'hDCBA, 1'b1);
    cycle(4'b1111, 16'hDCBA, 1'b1);
    chk("mid_pre_ptr_sel", out_sel, 1);
    do_reset();
    cycle(4'b1111, 16'hDCBA, 1'b1);
    chk("mid_restart", out_sel, 0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(4'b1010, 16'h4321, 1'b1);
      chk("sparse_sel", out_sel, (k % 2) ? 3 : 1);
    end
    cycle(4'b0100, 16'h0500, 1'b1);
    chk("bp_load", out_data, 5);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b1111, 16'h9876, 1'b0);
      chk("bp_hold_data", out_data, 5);
      chk("bp_hold_sel", out_sel, 2);
    end
    cycle(4'b1111, 16'h9876, 1'b1);
    chk("bp_next", out_sel, 3);
    cycle(4'b0000, 16'h0000, 1'b1);
    chk("pop_valid", out_valid, 0);
    cycle(4'b1111, 16'h1111, 1'b1);
    chk("pop_ptr", out_sel, 0);
    for (int k = 0; k < 400; k++) begin
      cycle(4'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
      if (k == 200) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
